// File: rtl/ext_irq_debounce.sv
// ext_irq_debounce
//   Turns the raw, bouncing BTNC push-button into a clean, level-held external
//   interrupt request for the SoC interrupt logic.
//
//   The pin is brought into the clk domain by a two-flop synchroniser. A
//   consecutive-sample filter then accepts a new level only after it has been
//   stable for DEBOUNCE_CYCLES edges. Each accepted press produces a one-cycle
//   strobe, bumps a wrapping press counter and, when enabled, raises a pending
//   request. The request stays up until the CPU acknowledges it. A press that
//   lands on an unacknowledged request sets a sticky overrun flag.
//
// Ports
//   clk          system clock; all state updates on the rising edge
//   rst          asynchronous, active-high reset; clears every flop
//   btn_in       raw button pin (asynchronous to clk, bouncing)
//   irq_en       1 lets accepted presses raise irq_pending
//   irq_ack      single-cycle CPU acknowledge; clears irq_pending/irq_overrun
//   btn_level    debounced button level
//   press_pulse  one-cycle strobe per accepted press (0->1 of btn_level)
//   irq_pending  level-held interrupt request
//   irq_overrun  sticky: a press arrived while a request was still pending
//   press_count  accepted presses, wraps modulo 2^COUNT_W
module ext_irq_debounce #(
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int CNT_W           = 20,
  parameter int COUNT_W         = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_in,
  input  logic               irq_en,
  input  logic               irq_ack,
  output logic               btn_level,
  output logic               press_pulse,
  output logic               irq_pending,
  output logic               irq_overrun,
  output logic [COUNT_W-1:0] press_count
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;

  // The differing sample that brings the count to its last value is the one
  // that commits the new level.
  logic             accept;
  logic             press_ev;

  assign accept   = (s2 != btn_level) && (cnt == CNT_LAST);
  assign press_ev = press_pulse && irq_en;

  // Synchroniser and debounce filter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1          <= 1'b0;
      s2          <= 1'b0;
      cnt         <= '0;
      btn_level   <= 1'b0;
      press_pulse <= 1'b0;
    end else begin
      s1 <= btn_in;
      s2 <= s1;
      // Any sample matching the current level restarts the count, so bounce
      // shorter than the threshold can never be accepted.
      if (s2 == btn_level) begin
        cnt <= '0;
      end else if (accept) begin
        btn_level <= s2;
        cnt       <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      // Only a rising accepted level is a press; releases are silent.
      press_pulse <= accept && s2;
    end
  end

  // Press counter and interrupt request, one edge after the strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      press_count <= '0;
      irq_pending <= 1'b0;
      irq_overrun <= 1'b0;
    end else begin
      if (press_pulse) begin
        press_count <= press_count + COUNT_W'(1);
      end
      // A new event outranks an acknowledge arriving on the same edge, so the
      // request is never lost; the ack still clears the overrun history.
      if (press_ev && !irq_pending) begin
        irq_pending <= 1'b1;
      end else if (press_ev && !irq_ack) begin
        irq_overrun <= 1'b1;
      end else if (press_ev) begin
        irq_pending <= 1'b1;
        irq_overrun <= 1'b0;
      end else if (irq_ack) begin
        irq_pending <= 1'b0;
        irq_overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ext_irq_debounce.sv
module tb_ext_irq_debounce;

  logic       clk;
  logic       rst;
  logic       btn_in;
  logic       irq_en;
  logic       irq_ack;
  logic       btn_level;
  logic       press_pulse;
  logic       irq_pending;
  logic       irq_overrun;
  logic [7:0] press_count;

  int tests;
  int failed;

  ext_irq_debounce #(
    .DEBOUNCE_CYCLES(8),
    .CNT_W(20),
    .COUNT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_in(btn_in),
    .irq_en(irq_en),
    .irq_ack(irq_ack),
    .btn_level(btn_level),
    .press_pulse(press_pulse),
    .irq_pending(irq_pending),
    .irq_overrun(irq_overrun),
    .press_count(press_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges; inputs are driven and outputs sampled 1 ns later.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic hold(input logic v, input int n);
    btn_in = v;
    tick(n);
  endtask

  task automatic do_reset();
    btn_in  = 1'b0;
    irq_en  = 1'b1;
    irq_ack = 1'b0;
    rst     = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic any_high;
    logic seen_pulse;
    int   pulse_at;
    any_high   = 1'b0;
    btn_in     = 1'b0;
    irq_en     = 1'b1;
    irq_ack    = 1'b0;
    rst        = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      if (btn_level || press_pulse || irq_pending || irq_overrun || press_count != 8'd0)
        any_high = 1'b1;
    end
    tests++;
    if (any_high !== 1'b0) begin
      failed++;
      $display("FAIL reset_outputs: got some output nonzero=%0b expected 0", any_high);
    end
    rst    = 1'b0;
    btn_in = 1'b1;
    seen_pulse = 1'b0;
    pulse_at   = 0;
    tick(9);
    tests++;
    if (btn_level !== 1'b0) begin
      failed++;
      $display("FAIL reset_level_edge9: got %0b expected 0", btn_level);
    end
    tick(1);
    tests++;
    if (btn_level !== 1'b1 || press_pulse !== 1'b1 || irq_pending !== 1'b0) begin
      failed++;
      $display("FAIL reset_edge10: got level=%0b pulse=%0b pend=%0b expected 1 1 0",
               btn_level, press_pulse, irq_pending);
    end
    tick(1);
    tests++;
    if (press_pulse !== 1'b0 || irq_pending !== 1'b1 || press_count !== 8'd1) begin
      failed++;
      $display("FAIL reset_edge11: got pulse=%0b pend=%0b count=%0d expected 0 1 1",
               press_pulse, irq_pending, press_count);
    end
  endtask

  task automatic test_bounce();
    logic seen;
    do_reset();
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      btn_in = ((i / 4) % 2) == 0;
      tick(1);
      if (btn_level || press_pulse) seen = 1'b1;
    end
    hold(1'b0, 12);
    tests++;
    if (seen !== 1'b0 || btn_level !== 1'b0) begin
      failed++;
      $display("FAIL bounce_reject: got seen=%0b level=%0b expected 0 0", seen, btn_level);
    end
    tests++;
    if (press_count !== 8'd0) begin
      failed++;
      $display("FAIL bounce_count: got %0d expected 0", press_count);
    end
    irq_ack = 1'b1;
    tick(1);
    irq_ack = 1'b0;
    tests++;
    if (irq_pending !== 1'b0 || irq_overrun !== 1'b0 || press_count !== 8'd0) begin
      failed++;
      $display("FAIL idle_ack: got pend=%0b ovr=%0b count=%0d expected 0 0 0",
               irq_pending, irq_overrun, press_count);
    end
  endtask

  task automatic test_bounce_settle();
    int pulses;
    int pulse_at;
    do_reset();
    pulses   = 0;
    pulse_at = -1;
    for (int i = 0; i < 16; i++) begin
      btn_in = ((i / 4) % 2) == 0;
      tick(1);
      if (press_pulse) pulses++;
    end
    btn_in = 1'b1;
    for (int t = 1; t <= 20; t++) begin
      tick(1);
      if (press_pulse) begin
        pulses++;
        if (pulse_at < 0) pulse_at = t;
      end
    end
    tests++;
    if (pulses !== 1 || pulse_at !== 10) begin
      failed++;
      $display("FAIL settle_pulse: got pulses=%0d at edge %0d expected 1 at 10", pulses, pulse_at);
    end
    tests++;
    if (press_count !== 8'd1) begin
      failed++;
      $display("FAIL settle_count: got %0d expected 1", press_count);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    hold(1'b1, 12);
    tests++;
    if (irq_pending !== 1'b1 || irq_overrun !== 1'b0) begin
      failed++;
      $display("FAIL ovr_first: got pend=%0b ovr=%0b expected 1 0", irq_pending, irq_overrun);
    end
    hold(1'b0, 12);
    hold(1'b1, 12);
    tests++;
    if (irq_pending !== 1'b1 || irq_overrun !== 1'b1 || press_count !== 8'd2) begin
      failed++;
      $display("FAIL ovr_second: got pend=%0b ovr=%0b count=%0d expected 1 1 2",
               irq_pending, irq_overrun, press_count);
    end
    irq_ack = 1'b1;
    tick(1);
    irq_ack = 1'b0;
    tests++;
    if (irq_pending !== 1'b0 || irq_overrun !== 1'b0 || press_count !== 8'd2) begin
      failed++;
      $display("FAIL ovr_ack: got pend=%0b ovr=%0b count=%0d expected 0 0 2",
               irq_pending, irq_overrun, press_count);
    end
    hold(1'b0, 12);
  endtask

  task automatic test_ack_collision();
    do_reset();
    hold(1'b1, 12);
    hold(1'b0, 12);
    btn_in = 1'b1;
    tick(10);
    tests++;
    if (press_pulse !== 1'b1 || irq_pending !== 1'b1) begin
      failed++;
      $display("FAIL coll_setup: got pulse=%0b pend=%0b expected 1 1", press_pulse, irq_pending);
    end
    irq_ack = 1'b1;
    tick(1);
    irq_ack = 1'b0;
    tests++;
    if (irq_pending !== 1'b1 || irq_overrun !== 1'b0 || press_count !== 8'd2) begin
      failed++;
      $display("FAIL coll_result: got pend=%0b ovr=%0b count=%0d expected 1 0 2",
               irq_pending, irq_overrun, press_count);
    end
    hold(1'b0, 12);
  endtask

  task automatic test_mask_and_async_reset();
    do_reset();
    irq_en = 1'b0;
    hold(1'b1, 12);
    tests++;
    if (irq_pending !== 1'b0 || press_count !== 8'd1 || btn_level !== 1'b1) begin
      failed++;
      $display("FAIL mask_press: got pend=%0b count=%0d level=%0b expected 0 1 1",
               irq_pending, press_count, btn_level);
    end
    hold(1'b0, 12);
    irq_en = 1'b1;
    btn_in = 1'b1;
    tick(7);
    tests++;
    if (dut.cnt !== 20'd5) begin
      failed++;
      $display("FAIL mid_cnt: got %0d expected 5", dut.cnt);
    end
    rst = 1'b1;
    #2;
    tests++;
    if (dut.cnt !== 20'd0 || btn_level !== 1'b0 || press_count !== 8'd0) begin
      failed++;
      $display("FAIL async_rst: got cnt=%0d level=%0b count=%0d expected 0 0 0",
               dut.cnt, btn_level, press_count);
    end
    tick(2);
    rst = 1'b0;
    btn_in = 1'b0;
    tick(2);
  endtask

  initial begin
    tests   = 0;
    failed  = 0;
    rst     = 1'b1;
    btn_in  = 1'b0;
    irq_en  = 1'b1;
    irq_ack = 1'b0;
    test_reset();
    test_bounce();
    test_bounce_settle();
    test_overrun();
    test_ack_collision();
    test_mask_and_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/ext_irq_debounce.md
Name: ext_irq_debounce

Overview:
Conditions the raw BTNC push-button into a clean, level-held external interrupt request for the SoC interrupt logic inside top.
- Synchronises the asynchronous pin into the CPU clock domain.
- Rejects contact bounce with a consecutive-sample filter.
- Converts each debounced press into a pending flag that stays asserted until the CPU acknowledges it.
- Keeps a press counter and a sticky overrun flag for software diagnostics.

Parameters:
DEBOUNCE_CYCLES, 8, consecutive stable cycles of the synchronised input needed to accept a new level; legal range 1..2^CNT_W-1.
CNT_W, 20, debounce counter width.
COUNT_W, 8, press counter width.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
btn_in  input  1  raw BTNC pin; asynchronous to clk and bouncing.
irq_en  input  1  interrupt enable; 0 stops presses from setting irq_pending.
irq_ack  input  1  single-cycle acknowledge from the CPU; clears irq_pending and irq_overrun.
btn_level  output  1  debounced button level.
press_pulse  output  1  one-cycle strobe per accepted press.
irq_pending  output  1  interrupt request to the core; level-held.
irq_overrun  output  1  sticky flag: a press arrived while an unacknowledged request was pending.
press_count  output  COUNT_W  number of accepted presses; wraps modulo 2^COUNT_W.

Behaviour:
- Reset: asynchronous assertion, synchronous-release-safe.
  - All flops clear to 0: sync stages s1/s2, cnt, btn_level, press_pulse, irq_pending, irq_overrun, press_count.
  - Reset mid-debounce discards the partial count.
- Synchroniser: s1 <= btn_in; s2 <= s1. Only s2 is used downstream.
- Debounce, evaluated every edge:
  - If s2 == btn_level: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: btn_level <= s2, cnt <= 0.
  - Else cnt <= cnt+1.
  - Any sample of s2 equal to btn_level before the threshold restarts the count, so bounce shorter than DEBOUNCE_CYCLES is never accepted.
- Latency: btn_level rises exactly DEBOUNCE_CYCLES+2 edges after the first edge that samples btn_in high, provided btn_in stays high. Release uses the same latency.
- Press detection: press_pulse <= 1 on the edge where btn_level goes 0->1, otherwise 0. Width is exactly one cycle. Release produces no pulse.
- press_count increments on every press_pulse regardless of irq_en; it wraps from 2^COUNT_W-1 to 0.
- Priority on each edge, with p = press_pulse && irq_en:
  - p && !irq_pending: irq_pending <= 1.
  - p && irq_pending && !irq_ack: irq_overrun <= 1; irq_pending stays 1.
  - p && irq_ack: irq_pending <= 1 (new event wins); irq_overrun <= 0.
  - !p && irq_ack: irq_pending <= 0; irq_overrun <= 0.
  - Otherwise both hold.
- The effect of press_pulse is seen on the edge after the pulse cycle, so irq_pending rises DEBOUNCE_CYCLES+3 edges after btn_in is first sampled high.
- irq_en = 0 masks new requests only. It does not clear an existing irq_pending.
- Button held through reset release: btn_level rises DEBOUNCE_CYCLES+2 cycles after release and generates a normal press. This is required behaviour.
- irq_ack while nothing is pending is harmless; no state changes.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=8 and irq_en=1 unless noted.
1. Reset hold 4 cycles, then btn_in=1 steady -> btn_level=1 after 10 edges; press_pulse high exactly 1 cycle; irq_pending=1 on edge 11; press_count=1; outputs all 0 during reset.
2. Bounce: btn_in toggles every 4 cycles (40 ns at 100 MHz) for 200 cycles, then holds 0 -> btn_level never rises; press_pulse never asserts; press_count=0.
3. Bounce then settle: 3 toggles of 4 cycles each, then hold 1 -> exactly one press_pulse, 10 edges after the final rising sample; press_count=1.
4. Two clean presses without ack -> irq_pending=1, irq_overrun=1. Then irq_ack for 1 cycle -> both 0 next edge; press_count=2.
5. irq_ack in the same cycle as press_pulse while pending -> irq_pending stays 1; irq_overrun=0.
6. irq_en=0 during a press -> irq_pending stays 0 and press_count increments. Then assert rst mid-debounce (cnt=5) -> cnt, btn_level and press_count return to 0 immediately, without waiting for a clock edge.
